// File: rtl/dmem_bus_ctrl.sv
//------------------------------------------------------------------------------
// dmem_bus_ctrl
//
// Data-side bus controller that sits between a single-cycle CPU datapath and
// (a) a slow, variable-latency data RAM and (b) a small on-chip MMIO page.
// It decodes the load/store address, runs a req/ack handshake with the RAM,
// stalls the datapath while a RAM access is outstanding, owns the LED register
// and a free-running cycle counter, and traps hung RAM accesses with a timeout.
//
// Ports:
//   clk, reset     - system clock (all state on posedge), synchronous active-high reset
//   cpu_addr       - byte address from the datapath ALU (bits [1:0] ignored)
//   cpu_wdata      - store data
//   cpu_rd/cpu_wr  - load / store in the current instruction (both = store)
//   cpu_rdata      - load data to the write-back mux (0 when no valid return)
//   cpu_stall      - hold PC/regfile; datapath enable = ~cpu_stall
//   mem_req        - registered RAM request
//   mem_we         - RAM write strobe, valid with mem_req
//   mem_addr       - RAM word address
//   mem_wdata      - RAM write data
//   mem_ack        - RAM completion, one-cycle pulse
//   mem_rdata      - RAM read data, valid with mem_ack
//   led            - LED register (MMIO +0)
//   bus_err        - sticky timeout flag (MMIO +8, write 1 to clear)
//   dbg_state      - current FSM state (0 IDLE, 1 WAIT, 2 DONE)
//
// RAM handshake: mem_req rises the cycle after the access is decoded and stays
// high, with mem_we/mem_addr/mem_wdata held stable, until the edge at which
// mem_ack is sampled high (or the timeout fires). mem_ack is only honoured
// while a request is outstanding; a pulse at any other time is dropped.
//
// The RAM window must be smaller than the address space
// (DMEM_AW + 2 < Dbits) for the decode below to be meaningful.
//------------------------------------------------------------------------------
module dmem_bus_ctrl #(
    parameter int unsigned      Dbits     = 32,
    parameter logic [Dbits-1:0] DMEM_BASE = 32'h1001_0000,
    parameter int unsigned      DMEM_AW   = 10,
    parameter logic [Dbits-1:0] MMIO_BASE = 32'h1003_0000,
    parameter int unsigned      TIMEOUT   = 16,
    // Reset value of the cycle counter; 0 in normal use, non-zero only to
    // exercise the wrap without running 2^32 cycles.
    parameter logic [31:0]      CNT_INIT  = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [Dbits-1:0]   cpu_addr,
    input  logic [Dbits-1:0]   cpu_wdata,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    output logic [Dbits-1:0]   cpu_rdata,
    output logic               cpu_stall,
    output logic               mem_req,
    output logic               mem_we,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [Dbits-1:0]   mem_wdata,
    input  logic               mem_ack,
    input  logic [Dbits-1:0]   mem_rdata,
    output logic [15:0]        led,
    output logic               bus_err,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [Dbits-1:0] DMEM_SIZE = Dbits'(1) << (DMEM_AW + 2);
    localparam int unsigned      TO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [Dbits-1:0] ABORT_VAL = Dbits'(32'hDEAD_BEEF);

    // Registers
    state_t              r_state;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [DMEM_AW-1:0]  r_mem_addr;
    logic [Dbits-1:0]    r_mem_wdata;
    logic [Dbits-1:0]    r_rdata;
    logic [TO_W-1:0]     r_to_cnt;
    logic [15:0]         r_led;
    logic                r_bus_err;
    logic [31:0]         r_cycle_cnt;

    // Combinational signals
    logic [Dbits-1:0]    w_dmem_off;
    logic                w_dmem_hit;
    logic                w_mmio_hit;
    logic                w_access;
    logic                w_load_only;
    logic [1:0]          w_mmio_sel;
    logic                w_mmio_wr;
    logic [Dbits-1:0]    w_mmio_rdata;
    state_t              w_state_next;
    logic                w_stall;
    logic [Dbits-1:0]    w_rdata;
    logic                w_launch;
    logic                w_ack_take;
    logic                w_timeout;

    //--------------------------------------------------------------------------
    // Address decode. Offsetting from the base and comparing against the
    // window size avoids an overflowing upper-bound constant.
    //--------------------------------------------------------------------------
    assign w_dmem_off  = cpu_addr - DMEM_BASE;
    assign w_dmem_hit  = (w_dmem_off < DMEM_SIZE);
    assign w_mmio_hit  = (cpu_addr[Dbits-1:4] == MMIO_BASE[Dbits-1:4]);
    assign w_access    = cpu_rd | cpu_wr;
    assign w_load_only = cpu_rd & ~cpu_wr;
    assign w_mmio_sel  = cpu_addr[3:2];

    // MMIO side effects only take place from IDLE: in DONE the datapath still
    // presents the completed RAM instruction, which cannot be an MMIO access.
    assign w_mmio_wr   = (r_state == S_IDLE) && cpu_wr && w_mmio_hit;

    always_comb begin
        w_mmio_rdata = '0;
        case (w_mmio_sel)
            2'd0:    w_mmio_rdata = Dbits'({16'b0, r_led});
            2'd1:    w_mmio_rdata = Dbits'(r_cycle_cnt);
            2'd2:    w_mmio_rdata = Dbits'(r_bus_err);
            default: w_mmio_rdata = '0;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM next-state and outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_rdata      = '0;
        w_launch     = 1'b0;
        w_ack_take   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && w_dmem_hit) begin
                    // Stall in the decode cycle itself so the datapath never
                    // commits before the RAM has answered.
                    w_stall      = 1'b1;
                    w_launch     = 1'b1;
                    w_state_next = S_WAIT;
                end else if (w_load_only && w_mmio_hit) begin
                    w_rdata = w_mmio_rdata;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                // Ack has priority over the timeout on the same cycle.
                if (mem_ack) begin
                    w_ack_take   = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // The datapath retires the instruction on this edge; its
                // cpu_rd/cpu_wr are not re-launched.
                w_state_next = S_IDLE;
                if (!r_mem_we) begin
                    w_rdata = r_rdata;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // State register and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_to_cnt    <= '0;
            r_led       <= '0;
            r_bus_err   <= 1'b0;
            r_cycle_cnt <= CNT_INIT;
        end else begin
            r_state     <= w_state_next;
            r_cycle_cnt <= r_cycle_cnt + 32'd1;

            if (w_launch) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= cpu_wr;
                r_mem_addr  <= cpu_addr[DMEM_AW+1:2];
                r_mem_wdata <= cpu_wdata;
                r_to_cnt    <= '0;
            end else if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
                if (w_ack_take) begin
                    r_mem_req <= 1'b0;
                    r_rdata   <= mem_rdata;
                end else if (w_timeout) begin
                    r_mem_req <= 1'b0;
                    r_rdata   <= ABORT_VAL;
                end
            end

            if (w_mmio_wr && (w_mmio_sel == 2'd0)) begin
                r_led <= cpu_wdata[15:0];
            end

            // Set has priority over a software clear in the same cycle.
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end else if (w_mmio_wr && (w_mmio_sel == 2'd2) && cpu_wdata[0]) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign cpu_rdata = w_rdata;
    assign cpu_stall = w_stall;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign led       = r_led;
    assign bus_err   = r_bus_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
//------------------------------------------------------------------------------
// tb_dmem_bus_ctrl
//
// Self-checking bench for dmem_bus_ctrl. Inputs are driven 1 time unit after
// the rising edge, outputs sampled on the falling edge. The bench plays the
// data RAM itself, acknowledging a chosen number of cycles after mem_req.
// Expected load/read data is pushed to exp_q when an access is launched and
// popped when the DUT returns data. A second instance with a counter preload
// close to 32'hFFFF_FFFF covers the cycle-counter wrap.
//------------------------------------------------------------------------------
module tb_dmem_bus_ctrl;

    localparam logic [31:0] MMIO = 32'h1003_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset2;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] led;
    logic        bus_err;
    logic [1:0]  dbg_state;

    logic [31:0] w2_rdata;
    logic        w2_stall;
    logic        w2_req;
    logic        w2_we;
    logic [9:0]  w2_maddr;
    logic [31:0] w2_mwdata;
    logic [15:0] w2_led;
    logic        w2_err;
    logic [1:0]  w2_dbg;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    dmem_bus_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .led       (led),
        .bus_err   (bus_err),
        .dbg_state (dbg_state)
    );

    dmem_bus_ctrl #(.CNT_INIT(32'hFFFF_FFFE)) u_wrap (
        .clk       (clk),
        .reset     (reset2),
        .cpu_addr  (MMIO + 32'd4),
        .cpu_wdata (32'h0),
        .cpu_rd    (1'b1),
        .cpu_wr    (1'b0),
        .cpu_rdata (w2_rdata),
        .cpu_stall (w2_stall),
        .mem_req   (w2_req),
        .mem_we    (w2_we),
        .mem_addr  (w2_maddr),
        .mem_wdata (w2_mwdata),
        .mem_ack   (1'b0),
        .mem_rdata (32'h0),
        .led       (w2_led),
        .bus_err   (w2_err),
        .dbg_state (w2_dbg)
    );

    //--------------------------------------------------------------------------
    // Driver: run one RAM access and report what was observed. Starts and ends
    // 1 unit after a rising edge; leaves cpu_rd/cpu_wr asserted for the caller.
    // ack_at = WAIT cycle (1-based) on which to ack, 0 = never ack.
    //--------------------------------------------------------------------------
    task automatic run_dmem_access(
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic        rd,
        input  logic        wr,
        input  int          ack_at,
        input  logic [31:0] ack_data,
        output int          stall_cyc,
        output int          req_cyc,
        output logic [9:0]  seen_addr,
        output logic        seen_we,
        output logic [31:0] seen_wdata,
        output logic        held_ok,
        output logic [31:0] done_rdata,
        output logic        done
    );
        stall_cyc  = 0;
        req_cyc    = 0;
        seen_addr  = '0;
        seen_we    = 1'b0;
        seen_wdata = '0;
        held_ok    = 1'b1;
        done_rdata = '0;
        done       = 1'b0;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        cpu_rd     = rd;
        cpu_wr     = wr;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                done_rdata = cpu_rdata;
                done       = 1'b1;
                break;
            end
            stall_cyc++;
            if (mem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    seen_addr  = mem_addr;
                    seen_we    = mem_we;
                    seen_wdata = mem_wdata;
                end else if (mem_addr !== seen_addr || mem_we !== seen_we || mem_wdata !== seen_wdata) begin
                    held_ok = 1'b0;
                end
                if (req_cyc == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ack_data;
                end
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got we=%b addr=%h wdata=%h expected all 0", mem_we, mem_addr, mem_wdata); end
        n_checks++; if (led !== 16'h0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_led_err: got led=%h err=%b expected 0/0", led, bus_err); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        @(posedge clk); #1;
        reset    = 1'b0;
        cpu_addr = MMIO + 32'd4;
        cpu_rd   = 1'b1;
        exp_q.push_back(32'd0);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_v) begin n_fail++; $display("FAIL reset_counter: got %h expected %h", cpu_rdata, exp_v); end
        exp_q.push_back(32'd5);
        repeat (5) @(posedge clk);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_v) begin n_fail++; $display("FAIL counter_run: got %h expected %h", cpu_rdata, exp_v); end
        @(posedge clk); #1;
        cpu_rd = 1'b0;
    endtask

    task automatic test_dmem_load();
        int st, rq, extra;
        logic [9:0] sa;
        logic swe, hok, dn;
        logic [31:0] swd, rdv;
        exp_q.push_back(32'h1234_5678);
        run_dmem_access(32'h1001_0010, 32'h0, 1'b1, 1'b0, 3, 32'h1234_5678, st, rq, sa, swe, swd, hok, rdv, dn);
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b expected 1", dn); end
        n_checks++; if (st != 4) begin n_fail++; $display("FAIL load_stall: got %0d expected 4", st); end
        n_checks++; if (rq != 3) begin n_fail++; $display("FAIL load_req_cycles: got %0d expected 3", rq); end
        n_checks++; if (sa !== 10'd4 || swe !== 1'b0) begin n_fail++; $display("FAIL load_addr_we: got %h/%b expected 004/0", sa, swe); end
        n_checks++; if (hok !== 1'b1) begin n_fail++; $display("FAIL load_held: got %b expected 1", hok); end
        exp_v = exp_q.pop_front();
        n_checks++; if (rdv !== exp_v) begin n_fail++; $display("FAIL load_rdata: got %h expected %h", rdv, exp_v); end
        cpu_rd = 1'b0;
        extra  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_req || cpu_stall) extra++;
            if (i == 1) mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL load_no_relaunch: got %0d busy cycles expected 0", extra); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL idle_ack_ignored: got state %0d expected 0", dbg_state); end
    endtask

    task automatic test_dmem_store();
        int st, rq;
        logic [9:0] sa;
        logic swe, hok, dn;
        logic [31:0] swd, rdv;
        exp_q.push_back(32'h0);
        run_dmem_access(32'h1001_0FFC, 32'hCAFE_F00D, 1'b0, 1'b1, 1, 32'h5555_5555, st, rq, sa, swe, swd, hok, rdv, dn);
        cpu_wr = 1'b0;
        n_checks++; if (dn !== 1'b1 || st != 2) begin n_fail++; $display("FAIL store_stall: got done=%b stall=%0d expected 1/2", dn, st); end
        n_checks++; if (sa !== 10'h3FF || swe !== 1'b1) begin n_fail++; $display("FAIL store_addr_we: got %h/%b expected 3ff/1", sa, swe); end
        n_checks++; if (swd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL store_wdata: got %h expected cafef00d", swd); end
        exp_v = exp_q.pop_front();
        n_checks++; if (rdv !== exp_v) begin n_fail++; $display("FAIL store_rdata: got %h expected %h", rdv, exp_v); end
    endtask

    task automatic test_back_to_back();
        int st, rq;
        logic [9:0] sa;
        logic swe, hok, dn;
        logic [31:0] swd, rdv;
        exp_q.push_back(32'h1111_0001);
        run_dmem_access(32'h1001_0000, 32'h0, 1'b1, 1'b0, 2, 32'h1111_0001, st, rq, sa, swe, swd, hok, rdv, dn);
        exp_v = exp_q.pop_front();
        n_checks++; if (st != 3 || sa !== 10'd0 || rdv !== exp_v) begin
            n_fail++; $display("FAIL b2b_first: got stall=%0d addr=%h rdata=%h expected 3/000/%h", st, sa, rdv, exp_v); end
        exp_q.push_back(32'h2222_0002);
        run_dmem_access(32'h1001_0004, 32'h0, 1'b1, 1'b0, 1, 32'h2222_0002, st, rq, sa, swe, swd, hok, rdv, dn);
        exp_v = exp_q.pop_front();
        n_checks++; if (st != 2 || sa !== 10'd1 || rdv !== exp_v) begin
            n_fail++; $display("FAIL b2b_second: got stall=%0d addr=%h rdata=%h expected 2/001/%h", st, sa, rdv, exp_v); end
        exp_q.push_back(32'h0);
        run_dmem_access(32'h1001_0008, 32'h7777_0003, 1'b1, 1'b1, 1, 32'h9999_9999, st, rq, sa, swe, swd, hok, rdv, dn);
        exp_v = exp_q.pop_front();
        n_checks++; if (swe !== 1'b1 || swd !== 32'h7777_0003 || rdv !== exp_v) begin
            n_fail++; $display("FAIL rdwr_is_store: got we=%b wdata=%h rdata=%h expected 1/77770003/%h", swe, swd, rdv, exp_v); end
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic test_mmio_led();
        cpu_addr  = MMIO;
        cpu_wdata = 32'h0001_A5A5;
        cpu_wr    = 1'b1;
        cpu_rd    = 1'b0;
        @(negedge clk);
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL led_wr_stall: got %b expected 0", cpu_stall); end
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL led_before_edge: got %h expected 0000", led); end
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        exp_q.push_back(32'h0000_A5A5);
        @(negedge clk);
        n_checks++; if (led !== 16'hA5A5) begin n_fail++; $display("FAIL led_value: got %h expected a5a5", led); end
        exp_v = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_v || cpu_stall !== 1'b0) begin
            n_fail++; $display("FAIL led_read: got %h stall=%b expected %h stall=0", cpu_rdata, cpu_stall, exp_v); end
        @(posedge clk); #1;
        cpu_wr    = 1'b1;
        cpu_wdata = 32'hFFFF_3C3C;
        exp_q.push_back(32'h0);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_v) begin n_fail++; $display("FAIL led_rdwr_rdata: got %h expected %h", cpu_rdata, exp_v); end
        @(posedge clk); #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        @(negedge clk);
        n_checks++; if (led !== 16'h3C3C) begin n_fail++; $display("FAIL led_rdwr_write: got %h expected 3c3c", led); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int st, rq;
        logic [9:0] sa;
        logic swe, hok, dn;
        logic [31:0] swd, rdv;
        exp_q.push_back(32'hDEAD_BEEF);
        run_dmem_access(32'h1001_0020, 32'h0, 1'b1, 1'b0, 0, 32'h0, st, rq, sa, swe, swd, hok, rdv, dn);
        cpu_rd = 1'b0;
        n_checks++; if (dn !== 1'b1 || st != 17) begin n_fail++; $display("FAIL timeout_stall: got done=%b stall=%0d expected 1/17", dn, st); end
        n_checks++; if (rq != 16) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d expected 16", rq); end
        exp_v = exp_q.pop_front();
        n_checks++; if (rdv !== exp_v) begin n_fail++; $display("FAIL timeout_rdata: got %h expected %h", rdv, exp_v); end
        cpu_addr = MMIO + 32'd8;
        cpu_rd   = 1'b1;
        exp_q.push_back(32'h1);
        @(negedge clk);
        n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_bus_err: got %b expected 1", bus_err); end
        exp_v = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_v) begin n_fail++; $display("FAIL status_read: got %h expected %h", cpu_rdata, exp_v); end
        @(posedge clk); #1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b1;
        cpu_wdata = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL status_clear_bit0_0: got %b expected 1", bus_err); end
        @(posedge clk); #1;
        cpu_wr    = 1'b1;
        cpu_wdata = 32'h0000_0001;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL status_clear: got %b expected 0", bus_err); end
        @(posedge clk); #1;
        exp_q.push_back(32'h0BAD_F00D);
        run_dmem_access(32'h1001_0024, 32'h0, 1'b1, 1'b0, 16, 32'h0BAD_F00D, st, rq, sa, swe, swd, hok, rdv, dn);
        cpu_rd = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (st != 17 || rdv !== exp_v) begin
            n_fail++; $display("FAIL ack_on_timeout: got stall=%0d rdata=%h expected 17/%h", st, rdv, exp_v); end
        @(negedge clk);
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL ack_on_timeout_err: got %b expected 0", bus_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_unmapped();
        logic [31:0] addrs [5] = '{32'h0000_0000, 32'h1003_000C, 32'h1001_1000, 32'h1000_FFFC, 32'h1003_0010};
        for (int i = 0; i < 5; i++) begin
            cpu_addr = addrs[i];
            cpu_rd   = 1'b1;
            exp_q.push_back(32'h0);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++; if (cpu_rdata !== exp_v || cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL unmapped_read_%0d: got rdata=%h stall=%b req=%b expected %h/0/0", i, cpu_rdata, cpu_stall, mem_req, exp_v); end
            @(posedge clk); #1;
        end
        cpu_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_addr  = addrs[i];
            cpu_wdata = 32'hFFFF_FFFF;
            cpu_wr    = 1'b1;
            @(negedge clk);
            n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL unmapped_wr_stall_%0d: got %b expected 0", i, cpu_stall); end
            @(posedge clk); #1;
        end
        cpu_wr = 1'b0;
        @(negedge clk);
        n_checks++; if (led !== 16'h3C3C || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL unmapped_wr_effect: got led=%h err=%b expected 3c3c/0", led, bus_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        int st, rq;
        logic [9:0] sa;
        logic swe, hok, dn;
        logic [31:0] swd, rdv;
        cpu_addr  = MMIO;
        cpu_wdata = 32'h0000_BEEF;
        cpu_wr    = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        exp_q.push_back(32'hDEAD_BEEF);
        run_dmem_access(32'h1001_0030, 32'h0, 1'b1, 1'b0, 0, 32'h0, st, rq, sa, swe, swd, hok, rdv, dn);
        cpu_rd = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (rdv !== exp_v || bus_err !== 1'b1 || led !== 16'hBEEF) begin
            n_fail++; $display("FAIL rst_setup: got rdata=%h err=%b led=%h expected %h/1/beef", rdv, bus_err, led, exp_v); end
        cpu_addr = 32'h1001_0040;
        cpu_rd   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || dbg_state !== 2'd1) begin
            n_fail++; $display("FAIL rst_pre_wait2: got req=%b state=%0d expected 1/1", mem_req, dbg_state); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFACE_FACE;
        cpu_addr  = MMIO + 32'd4;
        exp_q.push_back(32'h0);
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_wait: got req=%b stall=%b state=%0d expected 0/0/0", mem_req, cpu_stall, dbg_state); end
        n_checks++; if (led !== 16'h0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_regs: got led=%h err=%b expected 0000/0", led, bus_err); end
        exp_v = exp_q.pop_front();
        n_checks++; if (cpu_rdata !== exp_v) begin n_fail++; $display("FAIL rst_counter: got %h expected %h", cpu_rdata, exp_v); end
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cpu_rd    = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rst_late_ack: got req=%b state=%0d expected 0/0", mem_req, dbg_state); end
        @(posedge clk); #1;
    endtask

    task automatic test_counter_wrap();
        reset2 = 1'b1;
        @(posedge clk); #1;
        reset2 = 1'b0;
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_checks++; if (w2_rdata !== exp_v || w2_stall !== 1'b0) begin
                n_fail++; $display("FAIL counter_wrap_%0d: got %h stall=%b expected %h stall=0", i, w2_rdata, w2_stall, exp_v); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        reset2    = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_dmem_load();
        test_dmem_store();
        test_back_to_back();
        test_mmio_led();
        test_timeout();
        test_unmapped();
        test_reset_mid_wait();
        test_counter_wrap();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
